piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out transmitter. It accepts a WDT-bit word over a valid/ready handshake and shifts it out one bit per clock with a serial valid strobe and a last-bit marker. It is the transmit end for the team's serial-to-parallel capture logic and sits between a word-wide producer and a single-wire serial link.

## Interface
- WDT, 8, word width; legal range 2..64.
- IDLE_VAL, 0, level driven on ser_out whenever ser_valid is 0.
- MSB_FIRST, 1, bit order: 1 sends bit WDT-1 first, 0 sends bit 0 first.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- par_valid  input  1  producer has a word on par_data.
- par_data  input  WDT  word to transmit; sampled only on an accept.
- par_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a data bit this cycle.
- ser_last  output  1  ser_out is the final bit of the current word.
- busy  output  1  a word is being shifted or is held pending.

## Operation
- Accept: rising edge where par_valid && par_ready. par_data is captured, and par_data is ignored on all other edges.
- The producer must hold par_valid and par_data stable until it is accepted.
- There is no combinational path from par_valid or par_data to any output.
- States:
  - IDLE: ser_valid=0, ser_out=IDLE_VAL. An accept loads the shift register, clears bit_cnt and moves to SHIFT.
  - SHIFT: ser_valid=1. ser_out is the current head bit. bit_cnt increments each cycle, and ser_last=1 when bit_cnt==WDT-1.
  - On the last bit: if a next word is available (see Configuration), load it, clear bit_cnt and stay in SHIFT. Otherwise go to IDLE.
- bit_cnt is $clog2(WDT) bits wide and never wraps past WDT-1.
- Shift direction is set by MSB_FIRST. Bits shifted in behind the word are don't-care and never reach ser_out.
- busy = (state==SHIFT) || hold_full.
- Reset (any time, including mid-word):
  - state=IDLE, ser_out=IDLE_VAL, ser_valid=0, ser_last=0, busy=0.
  - Hold register empty and bit_cnt=0.
  - The partial word is discarded and there is no resumption after release.
  - par_ready reads 1 while in reset, but no accept occurs while rst_n is low.

## Timing
- Latency: accept on edge N puts the first bit on ser_out in cycle N+1. The last bit (ser_last=1) is in cycle N+WDT.
- ser_valid is high for exactly WDT consecutive cycles per word.
- ser_out, ser_valid and ser_last change only on clock edges, except on asynchronous reset assertion.
- Throughput without the hold feature: WDT+1 cycles per word (one IDLE cycle between words).
- Throughput with the hold feature: WDT cycles per word, with no gap.

## Configuration
- PISO_SERIALIZER_HOLD_EN undefined:
  - par_ready = (state==IDLE).
  - The block always returns to IDLE after the last bit.
- PISO_SERIALIZER_HOLD_EN defined:
  - Adds a one-word hold register and hold_full flag, and par_ready = !hold_full.
  - An accept in IDLE loads the shift register directly.
  - An accept in SHIFT on a non-last bit goes to the hold register.
  - On the last bit, a full hold register loads the shift register and clears hold_full.
  - On the last bit with the hold register empty and an accept in that same cycle, the word loads the shift register directly and hold stays empty.
  - Result: gapless back-to-back output.

## Structure
- Package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t.
  - A function returning the counter width for WDT.
- The hold register is a natural sub-module: instantiate d_flip_flop with WDT width and RST_VAL 0, enabled by a load mux. Everything else stays in piso_serializer.

## Test plan
- Reset, then idle 5 cycles: ser_out=IDLE_VAL, ser_valid=0, ser_last=0, par_ready=1, busy=0.
- Single word (WDT=8, MSB_FIRST=1), send 0xA5 at edge 0:
  - Cycles 1..8: ser_out = 1,0,1,0,0,1,0,1.
  - ser_last=1 only in cycle 8.
  - Cycle 9: ser_valid=0.
- LSB first (MSB_FIRST=0), send 0x01: ser_out = 1 in cycle 1, then 0 for cycles 2..8.
- Back-to-back 0xA5 then 0x3C with par_valid held high:
  - Without HOLD_EN: 0x3C is accepted at edge 9, its bits appear in cycles 10..17, and ser_valid=0 in cycle 9.
  - With HOLD_EN: 0x3C is accepted at edge 1, its bits appear in cycles 9..16, ser_valid stays 1 through cycles 1..16, and par_ready=0 in cycles 2..8.
- Backpressure (no HOLD_EN): par_data is changed while busy and par_valid is held. The transmitted word equals par_data at the accepting edge, not any earlier value.
- Reset mid-word: drop rst_n during bit 3 of 0xFF.
  - ser_valid goes to 0 and ser_out to IDLE_VAL immediately.
  - After release: IDLE, no residual bits, and the next accepted 0x0F transmits correctly.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// piso_pkg: shared state type and sizing helper for the PISO serializer.
// Imported by piso_serializer.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;

   // Width of the bit counter for a WDT-bit word. It never drops below 1 bit.
   function automatic int piso_cnt_width(input int wdt);
      return (wdt <= 2) ? 1 : $clog2(wdt);
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word-side handshake plus serial-side outputs of the
// PISO serializer.
// master = producer/observer side, slave = serializer side.
interface piso_serializer_if #(
   parameter int WDT = 8
);
   logic           par_valid;
   logic [WDT-1:0] par_data;
   logic           par_ready;
   logic           ser_out;
   logic           ser_valid;
   logic           ser_last;
   logic           busy;

   modport master (
      output par_valid, par_data,
      input  par_ready, ser_out, ser_valid, ser_last, busy
   );

   modport slave (
      input  par_valid, par_data,
      output par_ready, ser_out, ser_valid, ser_last, busy
   );
endinterface

// File: rtl/piso_serializer_dff.sv
// d_flip_flop: WIDTH-bit enabled register with asynchronous active-low reset.
// Used as the one-word hold register of the serializer.
module d_flip_flop #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d when enabled. Reset returns the register to RST_VAL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter.
// Accepts a WDT-bit word on a valid/ready handshake.
// Shifts the word out one bit per clock and marks each bit with ser_valid.
// ser_last flags the final bit of the word.
// Optional feature macro: PISO_SERIALIZER_HOLD_EN. When defined, it adds a
// one-word hold register so that consecutive words go out with no gap.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int   WDT       = 8,
   parameter logic IDLE_VAL  = 1'b0,
   parameter logic MSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   piso_serializer_if.slave   bus
);

   localparam int             CW       = piso_cnt_width(WDT);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WDT - 1);
   localparam logic [0:0]     ST_IDLE  = 1'(IDLE);
   localparam logic [0:0]     ST_SHIFT = 1'(SHIFT);

   logic [0:0]     state_reg, state_next;
   logic [CW-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [WDT-1:0] shift_reg, shift_next;

   logic           in_shift;
   logic           last_bit;
   logic           accept;
   logic           head_bit;
   logic [WDT-1:0] shifted;
   logic           hold_full;
   logic [WDT-1:0] hold_data;

   assign in_shift = (state_reg == ST_SHIFT);
   assign last_bit = in_shift && (bit_cnt_reg == LAST_CNT);
   assign accept   = bus.par_valid && bus.par_ready;

   // The head of the word always sits at the end nearest to ser_out.
   // Filler shifted in from the other end never reaches the head within
   // one word.
   assign head_bit = MSB_FIRST ? shift_reg[WDT-1] : shift_reg[0];
   assign shifted  = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);

`ifdef PISO_SERIALIZER_HOLD_EN
   logic hold_full_reg, hold_full_next;
   logic hold_load;

   // A word offered mid-word (not on the last bit) is parked in the hold
   // register.
   assign hold_load     = accept && in_shift && !last_bit;
   assign bus.par_ready = !hold_full_reg;
   assign hold_full     = hold_full_reg;

   // Set the hold flag when a word is parked. Clear it when that word moves
   // into the shifter.
   always_comb begin
      hold_full_next = hold_full_reg;
      if (hold_load) begin
         hold_full_next = 1'b1;
      end else if (last_bit && hold_full_reg) begin
         hold_full_next = 1'b0;
      end
   end

   // Register the hold flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_full_reg <= 1'b0;
      end else begin
         hold_full_reg <= hold_full_next;
      end
   end

   d_flip_flop #(
      .WIDTH   (WDT),
      .RST_VAL ({WDT{1'b0}})
   ) u_hold (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (hold_load),
      .d     (bus.par_data),
      .q     (hold_data)
   );
`else
   // Without the hold register, a new word is taken only from IDLE.
   assign bus.par_ready = !in_shift;
   assign hold_full     = 1'b0;
   assign hold_data     = '0;
`endif

   // Next-state logic: load on accept, shift each SHIFT cycle, and chain or
   // return to IDLE after the last bit.
   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               shift_next   = bus.par_data;
               bit_cnt_next = '0;
               state_next   = ST_SHIFT;
            end
         end
         default: begin
            if (!last_bit) begin
               shift_next   = shifted;
               bit_cnt_next = bit_cnt_reg + CW'(1);
            end else if (hold_full) begin
               shift_next   = hold_data;
               bit_cnt_next = '0;
            end else if (accept) begin
               shift_next   = bus.par_data;
               bit_cnt_next = '0;
            end else begin
               bit_cnt_next = '0;
               state_next   = ST_IDLE;
            end
         end
      endcase
   end

   // State registers. Reset discards any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
      end
   end

   // All outputs decode registered state only, so there is no path from
   // par_valid or par_data.
   assign bus.ser_valid = in_shift;
   assign bus.ser_out   = in_shift ? head_bit : IDLE_VAL;
   assign bus.ser_last  = last_bit;
   assign bus.busy      = in_shift || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed and random checks of piso_serializer.
// Two instances are driven with the same word stream:
//   - one sends MSB first with idle level 0,
//   - the other sends LSB first with idle level 1.
// Expectations come from the word value and cycle index.
// Build with or without PISO_SERIALIZER_HOLD_EN.
module tb_piso_serializer;
   localparam int   WDT    = 8;
   localparam logic IDLE_M = 1'b0;
   localparam logic IDLE_L = 1'b1;
`ifdef PISO_SERIALIZER_HOLD_EN
   localparam bit   HOLD   = 1'b1;
`else
   localparam bit   HOLD   = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           par_valid;
   logic [WDT-1:0] par_data;
   int             n_checks = 0;
   int             n_fail   = 0;

   piso_serializer_if #(.WDT(WDT)) if_m ();
   piso_serializer_if #(.WDT(WDT)) if_l ();

   assign if_m.par_valid = par_valid;
   assign if_m.par_data  = par_data;
   assign if_l.par_valid = par_valid;
   assign if_l.par_data  = par_data;

   piso_serializer #(.WDT(WDT), .IDLE_VAL(IDLE_M), .MSB_FIRST(1'b1)) dut_m (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_m.slave)
   );

   piso_serializer #(.WDT(WDT), .IDLE_VAL(IDLE_L), .MSB_FIRST(1'b0)) dut_l (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_l.slave)
   );

   always #5 clk = ~clk;

   // Observed/expected are packed {ser_valid, ser_out, ser_last, par_ready, busy}.
   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed {vld,out,last,rdy,busy}=%b expected %b", tag, obs, exp);
      end
   endtask

   // When act is set, i is the 1-based bit position within word w.
   task automatic chk_cycle(input string tag, input int c, input bit act,
                            input logic [WDT-1:0] w, input int i, input bit rdy);
      logic [4:0] exp_m, exp_l, obs_m, obs_l;
      if (act) begin
         exp_m = {1'b1, w[WDT-i], (i == WDT), rdy, 1'b1};
         exp_l = {1'b1, w[i-1],   (i == WDT), rdy, 1'b1};
      end else begin
         exp_m = {1'b0, IDLE_M, 1'b0, rdy, 1'b0};
         exp_l = {1'b0, IDLE_L, 1'b0, rdy, 1'b0};
      end
      obs_m = {if_m.ser_valid, if_m.ser_out, if_m.ser_last, if_m.par_ready, if_m.busy};
      obs_l = {if_l.ser_valid, if_l.ser_out, if_l.ser_last, if_l.par_ready, if_l.busy};
      chk($sformatf("%s_msb_c%0d", tag, c), obs_m, exp_m);
      chk($sformatf("%s_lsb_c%0d", tag, c), obs_l, exp_l);
      $display("[%0t] %s cycle %0d word %h bit %0d act %0d", $time, tag, c, w, i, act);
   endtask

   // One isolated word, accepted on the first edge after the call.
   task automatic xmit_one(input string tag, input logic [WDT-1:0] w);
      par_valid = 1'b1;
      par_data  = w;
      for (int c = 1; c <= WDT + 1; c++) begin
         @(negedge clk);
         if (c <= WDT) chk_cycle(tag, c, 1'b1, w, c, HOLD);
         else          chk_cycle(tag, c, 1'b0, '0, 0, 1'b1);
         par_valid = 1'b0;
         par_data  = WDT'($urandom);
      end
   endtask

   // Two words with par_valid held high. When scramble is set, par_data
   // wanders until the second word's accepting edge.
   task automatic b2b(input string tag, input logic [WDT-1:0] w0,
                      input logic [WDT-1:0] w1, input bit scramble);
      int acc2, start2, last_c, i;
      bit act, rdy;
      logic [WDT-1:0] w;
      acc2   = HOLD ? 1 : WDT + 1;
      start2 = HOLD ? WDT + 1 : WDT + 2;
      last_c = start2 + WDT;
      par_valid = 1'b1;
      par_data  = w0;
      for (int c = 1; c <= last_c; c++) begin
         @(negedge clk);
         act = 1'b0; w = '0; i = 0;
         if (c <= WDT) begin
            act = 1'b1; w = w0; i = c;
         end else if (c >= start2 && c < start2 + WDT) begin
            act = 1'b1; w = w1; i = c - start2 + 1;
         end
         rdy = HOLD ? !(c >= 2 && c <= WDT) : !act;
         chk_cycle(tag, c, act, w, i, rdy);
         if (c < acc2) begin
            par_data = scramble ? (w1 ^ WDT'($urandom_range(1, (1 << WDT) - 1))) : w1;
         end else if (c == acc2) begin
            par_data = w1;
         end else begin
            par_valid = 1'b0;
            par_data  = WDT'($urandom);
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      par_valid = 1'b0;
      par_data  = '0;
      repeat (2) @(negedge clk);
      chk_cycle("in_reset", 0, 1'b0, '0, 0, 1'b1);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk_cycle("idle", k, 1'b0, '0, 0, 1'b1);
      end

      xmit_one("word_a5", 8'hA5);
      xmit_one("word_01", 8'h01);
      b2b("b2b_a5_3c", 8'hA5, 8'h3C, 1'b0);
      b2b("backpressure", 8'h96, 8'h5A, 1'b1);

      // Reset during the third bit of 0xFF.
      par_valid = 1'b1;
      par_data  = 8'hFF;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk_cycle("pre_rst", c, 1'b1, 8'hFF, c, HOLD);
         par_valid = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1 chk_cycle("rst_assert", 3, 1'b0, '0, 0, 1'b1);
      par_valid = 1'b1;
      par_data  = 8'h55;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         chk_cycle("rst_held", k, 1'b0, '0, 0, 1'b1);
      end
      par_valid = 1'b0;
      rst_n     = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk_cycle("post_rst", k, 1'b0, '0, 0, 1'b1);
      end
      xmit_one("word_0f", 8'h0F);

      for (int n = 0; n < 6; n++) xmit_one($sformatf("rand%0d", n), WDT'($urandom));
      for (int n = 0; n < 3; n++)
         b2b($sformatf("rand_b2b%0d", n), WDT'($urandom), WDT'($urandom), 1'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
